// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the three-port SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int NPORT = 3;

  // Port indices
  localparam logic [1:0] P_CPU = 2'd0;
  localparam logic [1:0] P_GFX = 2'd1;
  localparam logic [1:0] P_SND = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sdram_arb_rr_pick.sv
// ============================================================================
// Module      : sdram_arb_rr_pick
// Description : 3-way round-robin selector. Searches the request vector
//               starting at i_start and returns a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb_rr_pick (
  input  logic [2:0] i_req,
  input  logic [1:0] i_start,
  output logic [2:0] o_gnt
);

  logic [2:0] w_rot;
  logic [2:0] w_pri;

  // Rotate so the starting port sits at bit 0, pick lowest, rotate back
  always_comb begin
    w_rot = i_req;
    case (i_start)
      2'd1:    w_rot = {i_req[0], i_req[2], i_req[1]};
      2'd2:    w_rot = {i_req[1], i_req[0], i_req[2]};
      default: w_rot = i_req;
    endcase

    w_pri = 3'b000;
    if (w_rot[0])      w_pri = 3'b001;
    else if (w_rot[1]) w_pri = 3'b010;
    else if (w_rot[2]) w_pri = 3'b100;

    o_gnt = w_pri;
    case (i_start)
      2'd1:    o_gnt = {w_pri[1], w_pri[0], w_pri[2]};
      2'd2:    o_gnt = {w_pri[0], w_pri[2], w_pri[1]};
      default: o_gnt = w_pri;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sdram_arb.sv
// ============================================================================
// Module      : sdram_arb
// Description : Three-port round-robin arbiter in front of the single-port
//               SDRAM controller, with a one-entry read cache per port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int BLANK   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [15:0]       din0,
  input  logic [1:0]        wtbt0,
  output logic              ack0,
  output logic              ack1,
  output logic              ack2,
  output logic [15:0]       dout0,
  output logic [15:0]       dout1,
  output logic [15:0]       dout2,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_wtbt,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_pend, r_ack, w_ack_nxt, w_hit, w_cand, w_gnt_oh, w_is_wr;
  logic                r_we0, r_op_we, r_err, r_mem_rd, r_mem_we;
  logic [15:0]         r_din0, r_mem_din;
  logic [1:0]          r_wtbt0, r_mem_wtbt, r_gnt, r_rr, w_gnt_idx;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_grant, w_done, w_tmo;
  logic [ADDR_W-1:0]   w_addr  [NPORT];
  logic [ADDR_W-1:0]   r_caddr [NPORT];
  logic [15:0]         r_cdata [NPORT];
  logic [15:0]         r_dout  [NPORT];
  logic [2:0]          r_cvalid;

  assign w_addr[0] = addr0;
  assign w_addr[1] = addr1;
  assign w_addr[2] = addr2;

  // Only P0 can carry a write; a pending write must never be served from cache
  assign w_is_wr = {2'b00, r_we0};

  for (genvar n = 0; n < NPORT; n++) begin : g_hit
    assign w_hit[n] = (r_state == IDLE) && r_pend[n] && r_cvalid[n] &&
                      !w_is_wr[n] && (w_addr[n] == r_caddr[n]);
  end

  assign w_cand = (r_state == IDLE) ? (r_pend & ~w_hit) : 3'b000;

  sdram_arb_rr_pick u_rr_pick (
    .i_req   (w_cand),
    .i_start (r_rr),
    .o_gnt   (w_gnt_oh)
  );

  assign w_grant   = |w_gnt_oh;
  assign w_gnt_idx = w_gnt_oh[2] ? P_SND : (w_gnt_oh[1] ? P_GFX : P_CPU);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, completion detection and ack generation
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = w_hit;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE:  if (w_grant) w_state_nxt = ISSUE;
      ISSUE: if (r_cnt == CNT_W'(BLANK - 1)) w_state_nxt = WAIT;
      WAIT: begin
        if (mem_ready)                           w_done = 1'b1;
        else if (r_cnt == CNT_W'(TIMEOUT - 1))   w_tmo  = 1'b1;
        if (w_done || w_tmo) begin
          w_ack_nxt[r_gnt] = 1'b1;
          w_state_nxt      = GAP;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Cycle counter for the blanking window and the ready timeout
  always_ff @(posedge clk) begin
    if (reset)                         r_cnt <= '0;
    else if (w_state_nxt != r_state)   r_cnt <= '0;
    else if (r_state == ISSUE || r_state == WAIT) r_cnt <= r_cnt + 1'b1;
  end

  // Pending latches; a new request in the ack cycle re-arms the port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend  <= '0;
      r_we0   <= 1'b0;
      r_din0  <= '0;
      r_wtbt0 <= '0;
    end else begin
      r_pend <= (r_pend & ~w_ack_nxt) | {req2, req1, req0};
      if (req0) begin
        r_we0   <= we0;
        r_din0  <= din0;
        r_wtbt0 <= wtbt0;
      end
    end
  end

  // Controller interface, read data, cache and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack      <= '0;
      r_gnt      <= P_CPU;
      r_rr       <= P_CPU;
      r_op_we    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wtbt <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_err      <= 1'b0;
      r_cvalid   <= '0;
      for (int n = 0; n < NPORT; n++) begin
        r_caddr[n] <= '0;
        r_cdata[n] <= '0;
        r_dout[n]  <= '0;
      end
    end else begin
      r_ack <= w_ack_nxt;
      for (int n = 0; n < NPORT; n++) begin
        if (w_hit[n]) r_dout[n] <= r_cdata[n];
      end
      // Address/data are loaded only here, so they stay frozen while rd/we is high
      if (w_grant) begin
        r_gnt      <= w_gnt_idx;
        r_rr       <= (w_gnt_idx == P_SND) ? P_CPU : w_gnt_idx + 2'd1;
        r_op_we    <= (w_gnt_idx == P_CPU) && r_we0;
        r_mem_addr <= w_addr[w_gnt_idx];
        r_mem_din  <= r_din0;
        r_mem_wtbt <= (w_gnt_idx == P_CPU) ? r_wtbt0 : 2'b11;
        r_mem_rd   <= !((w_gnt_idx == P_CPU) && r_we0);
        r_mem_we   <= (w_gnt_idx == P_CPU) && r_we0;
      end
      if (w_done || w_tmo) begin
        r_mem_rd <= 1'b0;
        r_mem_we <= 1'b0;
        if (r_op_we) r_cvalid <= '0;
      end
      if (w_done && !r_op_we) begin
        r_dout[r_gnt]   <= mem_dout;
        r_cdata[r_gnt]  <= mem_dout;
        r_caddr[r_gnt]  <= r_mem_addr;
        r_cvalid[r_gnt] <= 1'b1;
      end
      if (w_tmo) r_err <= 1'b1;
    end
  end

  assign ack0     = r_ack[0];
  assign ack1     = r_ack[1];
  assign ack2     = r_ack[2];
  assign dout0    = r_dout[0];
  assign dout1    = r_dout[1];
  assign dout2    = r_dout[2];
  assign err      = r_err;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_wtbt = r_mem_wtbt;
  assign mem_rd   = r_mem_rd;
  assign mem_we   = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arb.sv
// ============================================================================
// Module      : tb_sdram_arb
// Description : Directed self-checking bench for sdram_arb with a small
//               behavioural SDRAM controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_arb;

  localparam int ADDR_W  = 25;
  localparam int BLANK   = 2;
  localparam int TIMEOUT = 255;
  localparam int LAT     = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 0, req1 = 0, req2 = 0, we0 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [15:0]       din0 = '0;
  logic [1:0]        wtbt0 = '0;
  logic              ack0, ack1, ack2, err;
  logic [15:0]       dout0, dout1, dout2;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_wtbt;
  logic              mem_rd, mem_we;
  logic [15:0]       mem_dout = '0;
  logic              mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  sdram_arb #(.ADDR_W(ADDR_W), .BLANK(BLANK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2), .we0(we0),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .din0(din0), .wtbt0(wtbt0),
    .ack0(ack0), .ack1(ack1), .ack2(ack2),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .err(err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
    .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  logic              m_rd_q = 0, m_we_q = 0, m_dead = 0, m_is_wr = 0, st_valid = 0;
  int                m_cnt = 0, rd_edges = 0, we_edges = 0;
  logic [ADDR_W-1:0] st_addr = '0, last_waddr = '0;
  logic [15:0]       st_data = '0, last_wdin = '0;
  logic [1:0]        last_wtbt = '0, last_rtbt = '0;
  logic [ADDR_W-1:0] rise_addr [$];

  function automatic logic [15:0] fdef(input logic [ADDR_W-1:0] a);
    if (a == 25'h000100)      return 16'hBEEF;
    else if (a == 25'h000200) return 16'h1234;
    else                      return a[15:0] ^ 16'hA5A5;
  endfunction

  // Edge-triggered controller: ready pulses LAT cycles after a rd/we rise
  always @(posedge clk) begin
    m_rd_q    <= mem_rd;
    m_we_q    <= mem_we;
    mem_ready <= 1'b0;
    if (reset) begin
      m_cnt <= 0;
    end else if (mem_rd && !m_rd_q) begin
      rd_edges  <= rd_edges + 1;
      m_cnt     <= LAT;
      m_is_wr   <= 1'b0;
      last_rtbt <= mem_wtbt;
      rise_addr.push_back(mem_addr);
    end else if (mem_we && !m_we_q) begin
      we_edges   <= we_edges + 1;
      m_cnt      <= LAT;
      m_is_wr    <= 1'b1;
      last_wdin  <= mem_din;
      last_wtbt  <= mem_wtbt;
      last_waddr <= mem_addr;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_dead) begin
        mem_ready <= 1'b1;
        if (m_is_wr) begin
          st_addr  <= mem_addr;
          st_data  <= mem_din;
          st_valid <= 1'b1;
        end else begin
          mem_dout <= (st_valid && st_addr == mem_addr) ? st_data : fdef(mem_addr);
        end
      end
    end
  end

  int a0 = 0, a1 = 0, a2 = 0;
  always @(negedge clk) begin
    if (ack0) a0 <= a0 + 1;
    if (ack1) a1 <= a1 + 1;
    if (ack2) a2 <= a2 + 1;
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic pulse_req(input int port, input logic [ADDR_W-1:0] a,
                           input logic w, input logic [15:0] d, input logic [1:0] t);
    case (port)
      0: begin req0 = 1; addr0 = a; we0 = w; din0 = d; wtbt0 = t; end
      1: begin req1 = 1; addr1 = a; end
      default: begin req2 = 1; addr2 = a; end
    endcase
    @(negedge clk);
    req0 = 0; req1 = 0; req2 = 0;
  endtask

  task automatic wait_ack(input int port, input int budget, output int cyc, output bit seen);
    cyc = 0; seen = 0;
    while (cyc < budget) begin
      if ((port == 0 && ack0) || (port == 1 && ack1) || (port == 2 && ack2)) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    do_reset();
    checks++;
    if ({ack0, ack1, ack2, mem_rd, mem_we, err} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {ack0, ack1, ack2, mem_rd, mem_we, err});
    end
    checks++;
    if ({dout0, dout1, dout2} !== 48'h0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", {dout0, dout1, dout2});
    end
    checks++;
    if ({mem_addr, mem_din, mem_wtbt} !== '0) begin
      failures++; $display("FAIL reset_mem got=%h/%h/%b exp=0", mem_addr, mem_din, mem_wtbt);
    end
  endtask

  task automatic test_single_read();
    int cyc, r0, k0; bit seen;
    r0 = rd_edges; k0 = a1;
    pulse_req(1, 25'h000100, 0, 16'h0, 2'b00);
    wait_ack(1, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || cyc < BLANK + 2) begin
      failures++; $display("FAIL single_ack seen=%0d cycles=%0d need>=%0d", seen, cyc, BLANK + 2);
    end
    checks++;
    if (dout1 !== 16'hBEEF) begin
      failures++; $display("FAIL single_dout1 got=%h exp=beef", dout1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rd_edges - r0 != 1 || a1 - k0 != 1) begin
      failures++; $display("FAIL single_counts rd_edges=%0d acks=%0d exp=1/1", rd_edges - r0, a1 - k0);
    end
  endtask

  task automatic test_cache_hit();
    int cyc, r0; bit seen;
    r0 = rd_edges;
    pulse_req(1, 25'h000100, 0, 16'h0, 2'b00);
    wait_ack(1, 20, cyc, seen);
    checks++;
    if (!seen || cyc != 1) begin
      failures++; $display("FAIL hit_latency seen=%0d cycles=%0d exp=1", seen, cyc);
    end
    checks++;
    if (dout1 !== 16'hBEEF) begin
      failures++; $display("FAIL hit_dout1 got=%h exp=beef", dout1);
    end
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b0) begin
      failures++; $display("FAIL hit_ack_width got=%b exp=0", ack1);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_edges != r0 || mem_rd !== 1'b0) begin
      failures++; $display("FAIL hit_no_access rd_edges=%0d exp=%0d", rd_edges, r0);
    end
  endtask

  task automatic test_contention();
    int cyc, r0, k0, k1, k2;
    @(negedge clk);
    do_reset();
    r0 = rd_edges; k0 = a0; k1 = a1; k2 = a2;
    rise_addr.delete();
    req0 = 1; req1 = 1; req2 = 1; we0 = 0; wtbt0 = 2'b11;
    addr0 = 25'h000300; addr1 = 25'h000400; addr2 = 25'h000500;
    @(negedge clk);
    req0 = 0; req1 = 0; req2 = 0;
    cyc = 0;
    while (cyc < 200 && !(a0 > k0 && a1 > k1 && a2 > k2)) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a0 - k0 != 1 || a1 - k1 != 1 || a2 - k2 != 1) begin
      failures++; $display("FAIL cont_acks got=%0d/%0d/%0d exp=1/1/1", a0 - k0, a1 - k1, a2 - k2);
    end
    checks++;
    if (rd_edges - r0 != 3 || rise_addr.size() != 3) begin
      failures++; $display("FAIL cont_rd_edges got=%0d exp=3", rd_edges - r0);
    end else begin
      checks++;
      if (rise_addr[0] !== 25'h300 || rise_addr[1] !== 25'h400 || rise_addr[2] !== 25'h500) begin
        failures++; $display("FAIL cont_order got=%h,%h,%h exp=300,400,500",
                             rise_addr[0], rise_addr[1], rise_addr[2]);
      end
    end
    checks++;
    if (dout0 !== 16'hA6A5 || dout1 !== 16'hA1A5 || dout2 !== 16'hA0A5) begin
      failures++; $display("FAIL cont_dout got=%h/%h/%h exp=a6a5/a1a5/a0a5", dout0, dout1, dout2);
    end
  endtask

  task automatic test_write_invalidate();
    int cyc, r0, w0; bit seen;
    pulse_req(2, 25'h000200, 0, 16'h0, 2'b00);
    wait_ack(2, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || dout2 !== 16'h1234) begin
      failures++; $display("FAIL wi_first_read seen=%0d got=%h exp=1234", seen, dout2);
    end
    w0 = we_edges;
    pulse_req(0, 25'h000200, 1, 16'h5678, 2'b11);
    wait_ack(0, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || we_edges - w0 != 1 || last_wdin !== 16'h5678 || last_wtbt !== 2'b11 ||
        last_waddr !== 25'h000200) begin
      failures++; $display("FAIL wi_write seen=%0d we_edges=%0d din=%h wtbt=%b addr=%h exp=1/5678/11/200",
                           seen, we_edges - w0, last_wdin, last_wtbt, last_waddr);
    end
    r0 = rd_edges;
    pulse_req(2, 25'h000200, 0, 16'h0, 2'b00);
    wait_ack(2, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || rd_edges - r0 != 1 || dout2 !== 16'h5678) begin
      failures++; $display("FAIL wi_reread seen=%0d rd_edges=%0d got=%h exp=1/5678", seen, rd_edges - r0, dout2);
    end
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    m_dead = 1;
    pulse_req(0, 25'h000600, 0, 16'h0, 2'b00);
    wait_ack(0, 400, cyc, seen);
    checks++;
    if (!seen || cyc < TIMEOUT || cyc > TIMEOUT + BLANK + 6) begin
      failures++; $display("FAIL tmo_ack seen=%0d cycles=%0d exp=%0d..%0d", seen, cyc, TIMEOUT, TIMEOUT + BLANK + 6);
    end
    checks++;
    if (last_rtbt !== 2'b00) begin
      failures++; $display("FAIL tmo_wtbt_fwd got=%b exp=00", last_rtbt);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || dout0 !== 16'hA6A5) begin
      failures++; $display("FAIL tmo_err err=%b dout0=%h exp=1/a6a5", err, dout0);
    end
    m_dead = 0;
    pulse_req(1, 25'h000700, 0, 16'h0, 2'b00);
    wait_ack(1, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || dout1 !== 16'hA2A5 || err !== 1'b1) begin
      failures++; $display("FAIL tmo_next seen=%0d dout1=%h err=%b exp=1/a2a5/1", seen, dout1, err);
    end
  endtask

  task automatic test_reset_mid_access();
    int cyc, k1, r0; bit seen;
    pulse_req(1, 25'h000100, 0, 16'h0, 2'b00);
    wait_ack(1, 60, cyc, seen);
    repeat (2) @(negedge clk);
    pulse_req(1, 25'h000800, 0, 16'h0, 2'b00);
    cyc = 0;
    while (cyc < 20 && !mem_rd) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    k1 = a1;
    reset = 1;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0) begin
      failures++; $display("FAIL rst_mid_rd got=%b exp=0", mem_rd);
    end
    reset = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (a1 != k1 || mem_rd !== 1'b0) begin
      failures++; $display("FAIL rst_mid_noack acks=%0d exp=0 mem_rd=%b", a1 - k1, mem_rd);
    end
    r0 = rd_edges;
    pulse_req(1, 25'h000100, 0, 16'h0, 2'b00);
    wait_ack(1, 60, cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || rd_edges - r0 != 1 || dout1 !== 16'hBEEF) begin
      failures++; $display("FAIL rst_mid_miss seen=%0d rd_edges=%0d dout1=%h exp=1/1/beef",
                           seen, rd_edges - r0, dout1);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_cache_hit();
    test_contention();
    test_write_invalidate();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
